// File: rtl/imem_fetch_arbiter.sv
// Shares the combinational instruction-memory read port between IF fetch and a debug reader.
// The debug requester and its starvation counter exist only when IMEM_ARB_DBG_EN is defined.
module imem_fetch_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic        f_freeze,
  input  logic        f_flush,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data
);
  typedef enum logic [1:0] {RSP_NONE, RSP_F, RSP_D} rsp_e;

  rsp_e        r_state;
  logic [31:0] r_f_rdata;
  logic        w_fr;
  logic        w_f_gnt;
  logic        w_d_gnt;
  logic [31:0] w_addr;

  assign w_fr = f_req & ~f_freeze;

`ifdef IMEM_ARB_DBG_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]  r_starve;
  logic [31:0] r_d_rdata;
  logic        r_d_err;
  logic        w_d_win;

  // Debug takes the slot once it has been denied LIM cycles in a row.
  assign w_d_win = d_req & (r_starve == LIM);
  assign w_d_gnt = rst & d_req & (w_d_win | ~w_fr);
  assign w_f_gnt = rst & w_fr & ~w_d_win;
  assign w_addr  = w_d_gnt ? d_addr : f_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_starve <= '0;
    else if (!d_req || w_d_gnt) r_starve <= '0;
    else if (r_starve != LIM) r_starve <= r_starve + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_rdata <= '0;
      r_d_err   <= 1'b0;
    end else if (w_d_gnt) begin
      r_d_rdata <= mem_data;
      r_d_err   <= |d_addr[1:0];
    end
  end

  assign d_gnt    = w_d_gnt;
  assign d_rvalid = (r_state == RSP_D);
  assign d_rdata  = r_d_rdata;
  assign d_err    = r_d_err & d_rvalid;
`else
  logic w_unused;
  assign w_unused = ^{d_req, d_addr};

  assign w_d_gnt  = 1'b0;
  assign w_f_gnt  = rst & w_fr;
  assign w_addr   = f_addr;
  assign d_gnt    = 1'b0;
  assign d_rvalid = 1'b0;
  assign d_rdata  = '0;
  assign d_err    = 1'b0;
`endif

  // Misaligned low bits are dropped silently; the port only serves whole words.
  assign mem_addr = rst ? {w_addr[31:2], 2'b00} : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RSP_NONE;
      r_f_rdata <= '0;
    end else begin
      if (w_f_gnt)      r_state <= RSP_F;
      else if (w_d_gnt) r_state <= RSP_D;
      else              r_state <= RSP_NONE;
      if (w_f_gnt) r_f_rdata <= mem_data;
    end
  end

  assign f_gnt    = w_f_gnt;
  assign f_rvalid = (r_state == RSP_F) & ~f_flush;
  assign f_rdata  = r_f_rdata;
endmodule
